// File: rtl/regfile_2r1w_pkg.sv
// Shared defaults and helpers for the two-read / one-write register file.
package regfile_2r1w_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 8;

    // Address width for n entries, never less than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port: range check, write-first bypass, zero-register mask.
module regfile_rdport
    import regfile_2r1w_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ZERO_REG = 0,
    parameter int ADDR_W   = clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           rd_en,
    input  logic [ADDR_W-1:0]              rd_addr,
    input  logic [DEPTH-1:0][DATA_W-1:0]   mem,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic [DATA_W/8-1:0]            wr_mask,
    output logic [DATA_W-1:0]              rd_data,
    output logic                           rd_valid,
    output logic                           addr_bad
);

    localparam int NBYTE = DATA_W / 8;

    logic              in_range;
    logic              wr_hit;
    logic [DATA_W-1:0] stored;
    logic [DATA_W-1:0] merged;

    assign in_range = ({1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH));
    assign addr_bad = rd_en && !in_range;
    assign wr_hit   = wr_en && (wr_addr == rd_addr) && in_range;

    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    always_comb begin
        stored = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                stored = mem[i];
            end
        end

        merged = stored;
        for (int b = 0; b < NBYTE; b++) begin
            if (wr_hit && wr_mask[b]) begin
                merged[8*b +: 8] = wr_data[8*b +: 8];
            end
        end

        // Entry 0 is hard-wired to zero even when a write to it is bypassed.
        if (!in_range || (ZERO_REG != 0 && rd_addr == '0)) begin
            merged = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= merged;
            end
        end
    end

endmodule

// File: rtl/regfile_2r1w.sv
// Flip-flop register file with byte-masked write, two registered read ports and address-error flag.
module regfile_2r1w
    import regfile_2r1w_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ZERO_REG = 0
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      WrEn,
    input  logic [clog2(DEPTH)-1:0]   WrAddr,
    input  logic [DATA_W-1:0]         WrData,
    input  logic [DATA_W/8-1:0]       WrMask,
    input  logic                      RdEnA,
    input  logic [clog2(DEPTH)-1:0]   RdAddrA,
    input  logic                      RdEnB,
    input  logic [clog2(DEPTH)-1:0]   RdAddrB,
    output logic [DATA_W-1:0]         RdDataA,
    output logic [DATA_W-1:0]         RdDataB,
    output logic                      RdValidA,
    output logic                      RdValidB,
    output logic                      AddrErr
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int NBYTE  = DATA_W / 8;

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic                         wr_in_range;
    logic                         wr_bad;
    logic                         bad_a;
    logic                         bad_b;

    assign wr_in_range = ({1'b0, WrAddr} < (ADDR_W + 1)'(DEPTH));
    // An all-zero mask is no access at all, so it cannot be an address error.
    assign wr_bad      = WrEn && (|WrMask) && !wr_in_range;

    // NOTE: storage is plain flops rather than a RAM, so it can be cleared by reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mem <= '0;
        end else if (WrEn) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (WrAddr == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0)) begin
                    for (int b = 0; b < NBYTE; b++) begin
                        if (WrMask[b]) begin
                            mem[i][8*b +: 8] <= WrData[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            AddrErr <= 1'b0;
        end else begin
            AddrErr <= bad_a | bad_b | wr_bad;
        end
    end

    regfile_rdport #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG),
        .ADDR_W   (ADDR_W)
    ) u_port_a (
        .clk      (CLK),
        .rst_n    (RST),
        .rd_en    (RdEnA),
        .rd_addr  (RdAddrA),
        .mem      (mem),
        .wr_en    (WrEn),
        .wr_addr  (WrAddr),
        .wr_data  (WrData),
        .wr_mask  (WrMask),
        .rd_data  (RdDataA),
        .rd_valid (RdValidA),
        .addr_bad (bad_a)
    );

    regfile_rdport #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG),
        .ADDR_W   (ADDR_W)
    ) u_port_b (
        .clk      (CLK),
        .rst_n    (RST),
        .rd_en    (RdEnB),
        .rd_addr  (RdAddrB),
        .mem      (mem),
        .wr_en    (WrEn),
        .wr_addr  (WrAddr),
        .wr_data  (WrData),
        .wr_mask  (WrMask),
        .rd_data  (RdDataB),
        .rd_valid (RdValidB),
        .addr_bad (bad_b)
    );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench: a default instance and a DEPTH=6 / ZERO_REG=1 instance share one stimulus stream.
module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_mask;
    logic        rd_en_a, rd_en_b;
    logic [2:0]  rd_addr_a, rd_addr_b;

    logic [15:0] d_data_a, d_data_b, z_data_a, z_data_b;
    logic        d_valid_a, d_valid_b, z_valid_a, z_valid_b;
    logic        d_err, z_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    regfile_2r1w dut (
        .CLK (clk), .RST (rst_n),
        .WrEn (wr_en), .WrAddr (wr_addr), .WrData (wr_data), .WrMask (wr_mask),
        .RdEnA (rd_en_a), .RdAddrA (rd_addr_a), .RdEnB (rd_en_b), .RdAddrB (rd_addr_b),
        .RdDataA (d_data_a), .RdDataB (d_data_b),
        .RdValidA (d_valid_a), .RdValidB (d_valid_b), .AddrErr (d_err)
    );

    regfile_2r1w #(.DATA_W(16), .DEPTH(6), .ZERO_REG(1)) dut_z (
        .CLK (clk), .RST (rst_n),
        .WrEn (wr_en), .WrAddr (wr_addr), .WrData (wr_data), .WrMask (wr_mask),
        .RdEnA (rd_en_a), .RdAddrA (rd_addr_a), .RdEnB (rd_en_b), .RdAddrB (rd_addr_b),
        .RdDataA (z_data_a), .RdDataB (z_data_b),
        .RdValidA (z_valid_a), .RdValidB (z_valid_b), .AddrErr (z_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        rd_en_a = 1'b0;
        rd_en_b = 1'b0;
    endtask

    task automatic write(input logic [2:0] a, input logic [15:0] d, input logic [1:0] m);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_mask = m;
        step();
        wr_en = 1'b0;
    endtask

    logic [2:0]  rd_tbl  [3] = '{3'd1, 3'd4, 3'd2};
    logic [15:0] exp_tbl [3] = '{16'h0021, 16'h0022, 16'h0023};

    initial begin
        rst_n = 1'b0;
        idle();
        wr_addr = '0; wr_data = '0; wr_mask = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        #1;
        check("rst_data_a", d_data_a, 0);
        check("rst_valid_a", d_valid_a, 0);
        check("rst_err", d_err, 0);
        step();
        step();
        rst_n = 1'b1;

        // Fill entries; entry 6 is out of range for the DEPTH=6 instance.
        write(3'd1, 16'h0021, 2'b11);
        check("wr1_err_d", d_err, 0);
        check("wr1_err_z", z_err, 0);
        write(3'd4, 16'h0022, 2'b11);
        write(3'd2, 16'h0023, 2'b11);
        write(3'd3, 16'hAAAA, 2'b11);
        write(3'd5, 16'h0055, 2'b11);
        write(3'd6, 16'h0066, 2'b11);
        check("wr6_err_z", z_err, 1);
        check("wr6_err_d", d_err, 0);
        step();
        check("wr6_err_z_drop", z_err, 0);

        // Back-to-back reads, one-cycle latency.
        for (int i = 0; i < 3; i++) begin
            rd_en_a   = 1'b1;
            rd_addr_a = rd_tbl[i];
            step();
            check($sformatf("rd_a_%0d", i), d_data_a, exp_tbl[i]);
            check($sformatf("rd_va_%0d", i), d_valid_a, 1);
        end
        idle();
        step();
        check("hold_data_a", d_data_a, 16'h0023);
        check("hold_valid_a", d_valid_a, 0);

        // Write-first bypass with low-byte mask, both ports on the written entry.
        rd_en_a = 1'b1; rd_addr_a = 3'd3;
        rd_en_b = 1'b1; rd_addr_b = 3'd3;
        write(3'd3, 16'h1234, 2'b01);
        check("byp_a", d_data_a, 16'hAA34);
        check("byp_b", d_data_b, 16'hAA34);
        check("byp_z_a", z_data_a, 16'hAA34);
        rd_en_b = 1'b0;
        step();
        check("after_byp_a", d_data_a, 16'hAA34);

        // Independent ports; entry 6 out of range on the DEPTH=6 instance.
        rd_en_a = 1'b1; rd_addr_a = 3'd5;
        rd_en_b = 1'b1; rd_addr_b = 3'd6;
        step();
        check("dual_a", d_data_a, 16'h0055);
        check("dual_b", d_data_b, 16'h0066);
        check("dual_z_a", z_data_a, 16'h0055);
        check("dual_z_b", z_data_b, 16'h0000);
        check("dual_z_vb", z_valid_b, 1);
        check("dual_z_err", z_err, 1);
        check("dual_d_err", d_err, 0);
        idle();

        // Zero-mask writes: no storage change, no address error.
        write(3'd7, 16'hFFFF, 2'b00);
        check("m0_err_z", z_err, 0);
        write(3'd1, 16'hFFFF, 2'b00);
        rd_en_a = 1'b1; rd_addr_a = 3'd1;
        step();
        check("m0_rd_d", d_data_a, 16'h0021);
        idle();

        // Out-of-range write then read on the DEPTH=6 instance.
        write(3'd7, 16'hBEEF, 2'b11);
        check("oor_wr_err", z_err, 1);
        step();
        check("oor_wr_err_pulse", z_err, 0);
        rd_en_a = 1'b1; rd_addr_a = 3'd7;
        step();
        check("oor_rd_z", z_data_a, 16'h0000);
        check("oor_rd_zv", z_valid_a, 1);
        check("oor_rd_err", z_err, 1);
        check("oor_rd_d", d_data_a, 16'hBEEF);
        rd_addr_a = 3'd1;
        rd_en_b = 1'b1; rd_addr_b = 3'd5;
        step();
        check("oor_err_pulse", z_err, 0);
        check("oor_keep1", z_data_a, 16'h0021);
        check("oor_keep5", z_data_b, 16'h0055);
        idle();

        // Zero register, including a bypassed write to entry 0.
        rd_en_a = 1'b1; rd_addr_a = 3'd0;
        rd_en_b = 1'b1; rd_addr_b = 3'd0;
        write(3'd0, 16'hFFFF, 2'b11);
        check("z0_byp_a", z_data_a, 16'h0000);
        check("z0_byp_b", z_data_b, 16'h0000);
        check("z0_byp_err", z_err, 0);
        check("d0_byp_a", d_data_a, 16'hFFFF);
        step();
        check("z0_rd_a", z_data_a, 16'h0000);
        check("z0_rd_b", z_data_b, 16'h0000);
        check("z0_rd_err", z_err, 0);
        check("d0_rd_b", d_data_b, 16'hFFFF);
        idle();

        // Reset with a read pending: result discarded, no valid pulse.
        rd_en_a = 1'b1; rd_addr_a = 3'd1;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", d_data_a, 16'h0000);
        check("mid_rst_valid", d_valid_a, 0);
        step();
        check("mid_rst_edge_valid", d_valid_a, 0);
        rst_n = 1'b1;
        idle();
        step();
        check("post_rst_valid", d_valid_a, 0);

        for (int i = 0; i < 8; i++) begin
            rd_en_a = 1'b1; rd_addr_a = 3'(i);
            rd_en_b = 1'b1; rd_addr_b = 3'(7 - i);
            step();
            check($sformatf("clr_a_%0d", i), d_data_a, 16'h0000);
            check($sformatf("clr_b_%0d", i), d_data_b, 16'h0000);
            check($sformatf("clr_v_%0d", i), {d_valid_a, d_valid_b}, 2'b11);
        end
        idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
